// File: rtl/clk_div_phase_gen_if.sv
// Control/status bundle for clk_div_phase_gen: run request, reconfiguration
// handshake and the generated clock/strobe/lock outputs.
interface clk_div_phase_gen_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_divide;
    logic [CNT_W-1:0] cfg_phase;
    logic             clk_out;
    logic             tick;
    logic             locked;

    modport master (
        output en, cfg_valid, cfg_divide, cfg_phase,
        input  cfg_ready, clk_out, tick, locked
    );

    modport slave (
        input  en, cfg_valid, cfg_divide, cfg_phase,
        output cfg_ready, clk_out, tick, locked
    );
endinterface

// File: rtl/clk_div_phase_gen.sv
// Fabric divided-clock generator with programmable divide/phase, tick strobe
// and lock flag. Define CLKDIV_LOCK_EN to require LOCK_CYCLES periods before lock.
module clk_div_phase_gen #(
    parameter int CNT_W       = 8,
    parameter int DIVIDE      = 12,
    parameter int PHASE       = 3,
    parameter int LOCK_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    clk_div_phase_gen_if.slave   bus
);
    typedef enum logic [1:0] {ST_STOP, ST_DELAY, ST_RUN} state_t;

    localparam int D_RST_I = (DIVIDE < 2) ? 2 : DIVIDE;
    localparam int P_RST_I = (PHASE > D_RST_I - 1) ? D_RST_I - 1 : PHASE;
    localparam logic [CNT_W-1:0] D_RST = CNT_W'(D_RST_I);
    localparam logic [CNT_W-1:0] P_RST = CNT_W'(P_RST_I);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    if (CNT_W < 2 || LOCK_CYCLES < 1) begin : g_param_check
        $error("clk_div_phase_gen: CNT_W must be >= 2 and LOCK_CYCLES >= 1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d, ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, dcnt_q, dcnt_d;
    logic [CNT_W-1:0] new_div, new_ph;
    logic             clk_out_q, clk_out_d, tick_q, tick_d, locked_q, locked_d;
    logic             period_end, cfg_ready, accept;
`ifdef CLKDIV_LOCK_EN
    localparam int PC_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(LOCK_CYCLES);
    logic [PC_W-1:0]  pcnt_q, pcnt_d;
`endif

    assign period_end = (state_q == ST_RUN) && (cnt_q == div_q - ONE);
    assign cfg_ready  = (state_q == ST_STOP) || period_end;
    assign accept     = bus.cfg_valid && cfg_ready;
    // New phase is clamped against the divide being loaded alongside it.
    assign new_div    = (bus.cfg_divide < TWO) ? TWO : bus.cfg_divide;
    assign new_ph     = (bus.cfg_phase > new_div - ONE) ? new_div - ONE : bus.cfg_phase;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
`ifdef CLKDIV_LOCK_EN
        pcnt_d  = pcnt_q;
`endif
        if (accept) begin
            div_d = new_div;
            ph_d  = new_ph;
        end
        case (state_q)
            ST_STOP: begin
                if (bus.en) begin
                    if (ph_d == '0) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DELAY;
                        dcnt_d  = '0;
                    end
                end
            end
            ST_DELAY: begin
                if (!bus.en) begin
                    state_d = ST_STOP;
                end else if (dcnt_q == ph_q - ONE) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    dcnt_d = dcnt_q + ONE;
                end
            end
            ST_RUN: begin
                if (period_end) begin
`ifdef CLKDIV_LOCK_EN
                    if (pcnt_q != PC_MAX) pcnt_d = pcnt_q + PC_W'(1);
`endif
                    // Disable and reconfiguration only act at the period boundary.
                    if (!bus.en) begin
                        state_d = ST_STOP;
                    end else if (accept) begin
`ifdef CLKDIV_LOCK_EN
                        pcnt_d = '0;
`endif
                        if (new_ph == '0) begin
                            cnt_d = '0;
                        end else begin
                            state_d = ST_DELAY;
                            dcnt_d  = '0;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = ST_STOP;
        endcase
`ifdef CLKDIV_LOCK_EN
        if (state_d != ST_RUN) pcnt_d = '0;
`endif
        // Outputs are registered from next state so they align with it.
        clk_out_d = (state_d == ST_RUN) && (cnt_d < (div_d >> 1));
        tick_d    = (state_d == ST_RUN) && (cnt_d == '0);
`ifdef CLKDIV_LOCK_EN
        locked_d  = (state_d == ST_RUN) && (pcnt_d == PC_MAX);
`else
        locked_d  = (state_d == ST_RUN);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STOP;
            div_q     <= D_RST;
            ph_q      <= P_RST;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            locked_q  <= 1'b0;
`ifdef CLKDIV_LOCK_EN
            pcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            ph_q      <= ph_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            locked_q  <= locked_d;
`ifdef CLKDIV_LOCK_EN
            pcnt_q    <= pcnt_d;
`endif
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.clk_out   = clk_out_q;
    assign bus.tick      = tick_q;
    assign bus.locked    = locked_q;
endmodule

// File: tb/tb_clk_div_phase_gen.sv
// Bench for clk_div_phase_gen: directed timing scenarios plus a randomized run
// against a period/position reference model.
module tb_clk_div_phase_gen;
    localparam int CNT_W = 8;
    localparam int LOCK  = 4;
`ifdef CLKDIV_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    clk_div_phase_gen_if #(.CNT_W(CNT_W)) bus ();

    clk_div_phase_gen #(
        .CNT_W(CNT_W), .DIVIDE(12), .PHASE(3), .LOCK_CYCLES(LOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // {clk_out, tick, locked} for a run starting at cycle s with divide d.
    function automatic logic [2:0] pattern(int n, int s, int d, int lock_from);
        int pos;
        if (n < s) return 3'b000;
        pos = (n - s) % d;
        return {pos < d / 2, pos == 0, n >= lock_from};
    endfunction

    function automatic int lock_at(int s, int d);
        return LOCK_EN ? s + LOCK * d : s;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_divide = '0;
        bus.cfg_phase = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.en = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_divide = '0;
        bus.cfg_phase = '0;
        @(negedge clk);
        total++;
        if ({bus.clk_out, bus.tick, bus.locked, bus.cfg_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_state got=%b want=0001",
                     {bus.clk_out, bus.tick, bus.locked, bus.cfg_ready});
        end
        rst = 1'b0;
    endtask

    task automatic test_default_run();
        logic [3:0] got, want;
        do_reset();
        bus.en = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            want = {pattern(n, 4, 12, lock_at(4, 12)), (n >= 4) && ((n - 4) % 12 == 11)};
            got  = {bus.clk_out, bus.tick, bus.locked, bus.cfg_ready};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL default_run n=%0d got=%b want=%b", n, got, want);
            end
        end
    endtask

    task automatic test_reconfig();
        logic [3:0] got, want;
        do_reset();
        bus.en = 1'b1;
        for (int n = 1; n <= 95; n++) begin
            @(negedge clk);
            if (n < 64)
                want = {pattern(n, 4, 12, lock_at(4, 12)), (n >= 4) && ((n - 4) % 12 == 11)};
            else
                want = {pattern(n, 64, 5, lock_at(64, 5)), (n - 64) % 5 == 4};
            got = {bus.clk_out, bus.tick, bus.locked, bus.cfg_ready};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reconfig n=%0d got=%b want=%b", n, got, want);
            end
            if (n == 55) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_divide = 8'd5;
                bus.cfg_phase = 8'd0;
            end
            if (n == 64) bus.cfg_valid = 1'b0;
        end
    endtask

    task automatic test_clamp();
        logic [3:0] got, want;
        do_reset();
        bus.cfg_valid = 1'b1;
        bus.cfg_divide = 8'd1;
        bus.cfg_phase = 8'd9;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            want = {pattern(n, 2, 2, lock_at(2, 2)), (n >= 2) && ((n - 2) % 2 == 1)};
            got  = {bus.clk_out, bus.tick, bus.locked, bus.cfg_ready};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL clamp n=%0d got=%b want=%b", n, got, want);
            end
        end
    endtask

    task automatic test_disable();
        logic [3:0] got, want;
        do_reset();
        bus.en = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n < 16)
                want = {pattern(n, 4, 12, lock_at(4, 12)), (n >= 4) && ((n - 4) % 12 == 11)};
            else
                want = 4'b0001;
            got = {bus.clk_out, bus.tick, bus.locked, bus.cfg_ready};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL disable_run n=%0d got=%b want=%b", n, got, want);
            end
            if (n == 7) bus.en = 1'b0;
        end
        do_reset();
        bus.en = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            want = {3'b000, n >= 3};
            got  = {bus.clk_out, bus.tick, bus.locked, bus.cfg_ready};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL disable_delay n=%0d got=%b want=%b", n, got, want);
            end
            if (n == 2) bus.en = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got, want;
        do_reset();
        bus.cfg_valid = 1'b1;
        bus.cfg_divide = 8'd7;
        bus.cfg_phase = 8'd1;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.en = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.clk_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre got=%b want=1", bus.clk_out);
        end
        #2 rst = 1'b1;
        #1;
        got = {bus.clk_out, bus.tick, bus.locked, bus.cfg_ready};
        total++;
        if (got !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid_async got=%b want=0001", got);
        end
        bus.en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.en = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            want = {pattern(n, 4, 12, lock_at(4, 12)), (n >= 4) && ((n - 4) % 12 == 11)};
            got  = {bus.clk_out, bus.tick, bus.locked, bus.cfg_ready};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid_restart n=%0d got=%b want=%b", n, got, want);
            end
        end
    endtask

    task automatic test_random();
        int  m_d, m_p, m_left, m_pos, m_periods, nd, np, dv, ph;
        bit  m_run, m_dly, ready, acc, en, vld;
        logic [3:0] got, want;
        do_reset();
        m_d = 12; m_p = 3; m_left = 0; m_pos = 0; m_periods = 0;
        m_run = 0; m_dly = 0;
        for (int n = 1; n <= 1500; n++) begin
            @(negedge clk);
            ready = (!m_run && !m_dly) || (m_run && m_pos == m_d - 1);
            want = {m_run && (m_pos < m_d / 2), m_run && (m_pos == 0),
                    m_run && (!LOCK_EN || m_periods >= LOCK), ready};
            got  = {bus.clk_out, bus.tick, bus.locked, bus.cfg_ready};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL random n=%0d got=%b want=%b", n, got, want);
            end
            en  = ($urandom_range(0, 15) != 0);
            vld = ($urandom_range(0, 3) == 0);
            dv  = $urandom_range(0, 16);
            ph  = $urandom_range(0, 16);
            if (!m_run && !m_dly && en) vld = 0;
            bus.en = en;
            bus.cfg_valid = vld;
            bus.cfg_divide = 8'(dv);
            bus.cfg_phase = 8'(ph);
            acc = vld && ready;
            nd  = (dv < 2) ? 2 : dv;
            np  = (ph > nd - 1) ? nd - 1 : ph;
            if (!m_run && !m_dly) begin
                if (acc) begin m_d = nd; m_p = np; end
                if (en) begin
                    if (m_p == 0) begin m_run = 1; m_pos = 0; end
                    else begin m_dly = 1; m_left = m_p; end
                end
            end else if (m_dly) begin
                if (!en) m_dly = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_dly = 0; m_run = 1; m_pos = 0; end
                end
            end else if (m_pos == m_d - 1) begin
                m_periods++;
                if (acc) begin m_d = nd; m_p = np; end
                if (!en) begin
                    m_run = 0; m_periods = 0;
                end else if (acc) begin
                    m_periods = 0;
                    if (m_p == 0) m_pos = 0;
                    else begin m_run = 0; m_dly = 1; m_left = m_p; end
                end else begin
                    m_pos = 0;
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_reconfig();
        test_clamp();
        test_disable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
